my_clipper_ctrl: RTL



---
 rtl/my_clipper_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/my_clipper_ctrl.sv
// my_clipper_ctrl: crop-window controller that monitors an Avalon-ST video stream and drives clipper sizing and per-beat keep
module my_clipper_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_BITS   = 8,
  parameter int DATA_PLANES = 1,
  parameter int DEF_WIDTH   = 1920,
  parameter int DEF_HEIGHT  = 1080
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  input  logic                  din_ready,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  input  logic                  cfg_wr,
  input  logic [2:0]            cfg_addr,
  input  logic [15:0]           cfg_wdata,
  output logic [15:0]           video_width,
  output logic [15:0]           video_height,
  output logic [3:0]            video_interlaced,
  output logic                  pix_keep,
  output logic                  cfg_pending,
  output logic                  err_ctrl,
  output logic                  err_frame
);
  localparam logic [3:0] REQ = 4'((8 + DATA_PLANES) / DATA_PLANES);
  typedef enum logic [3:0] {IDLE = 4'b0001, CTRL = 4'b0010, VID = 4'b0100, SKIP = 4'b1000} state_t;
  state_t state;
  logic [3:0] nib [9];
  logic [3:0] nib_n [9];
  logic [3:0] bidx;
  logic [3:0] in_int;
  logic [15:0] in_width, in_height, x, y;
  logic [15:0] sh_l, sh_r, sh_t, sh_b, ac_l, ac_r, ac_t, ac_b;
  logic [15:0] nw_l, nw_r, nw_t, nw_b;
  logic [16:0] lr, tb;
  logic beat, sop_hdr, go_vid, clr, ctrl_bad, x_last, frame_bad;
  logic unused;
  assign unused = ^din_data;
  assign beat = din_valid & din_ready;
  assign sop_hdr = beat & din_startofpacket & ~din_endofpacket & (state == IDLE);
  assign go_vid = sop_hdr & (din_data[3:0] == 4'h0);
  assign clr = cfg_wr & (cfg_addr == 3'd5);
  assign nw_l = cfg_pending ? sh_l : ac_l;
  assign nw_r = cfg_pending ? sh_r : ac_r;
  assign nw_t = cfg_pending ? sh_t : ac_t;
  assign nw_b = cfg_pending ? sh_b : ac_b;
  assign lr = {1'b0, nw_l} + {1'b0, nw_r};
  assign tb = {1'b0, nw_t} + {1'b0, nw_b};
  assign x_last = {1'b0, x} + 17'd1 >= {1'b0, in_width};
  assign ctrl_bad = beat & (state == CTRL) & din_endofpacket & (bidx < REQ);
  assign frame_bad = beat & (state == VID) & ((y >= in_height) |
                     (din_endofpacket & ~(x_last & ({1'b0, y} + 17'd1 == {1'b0, in_height}))));
  assign pix_keep = ~rst & (state == VID) & din_valid & (x >= ac_l) &
                    ({1'b0, x} + {1'b0, ac_r} < {1'b0, in_width}) & (y >= ac_t) &
                    ({1'b0, y} + {1'b0, ac_b} < {1'b0, in_height});
  always_comb begin
    for (int k = 0; k < 9; k++) nib_n[k] = nib[k];
    for (int p = 0; p < DATA_PLANES; p++)
      for (int k = 0; k < 9; k++)
        if (k == (int'(bidx) - 1) * DATA_PLANES + p) nib_n[k] = din_data[p*DATA_BITS +: 4];
  end
  always_ff @(posedge clk)
    if (beat && state == CTRL) nib <= nib_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bidx <= '0;
      in_width <= 16'(DEF_WIDTH);
      in_height <= 16'(DEF_HEIGHT);
      in_int <= '0;
      {sh_l, sh_r, sh_t, sh_b} <= '0;
      {ac_l, ac_r, ac_t, ac_b} <= '0;
      x <= '0;
      y <= '0;
      video_width <= '0;
      video_height <= '0;
      video_interlaced <= '0;
      cfg_pending <= 1'b0;
      err_ctrl <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      sh_l <= (cfg_wr && cfg_addr == 3'd0) ? cfg_wdata : sh_l;
      sh_r <= (cfg_wr && cfg_addr == 3'd1) ? cfg_wdata : sh_r;
      sh_t <= (cfg_wr && cfg_addr == 3'd2) ? cfg_wdata : sh_t;
      sh_b <= (cfg_wr && cfg_addr == 3'd3) ? cfg_wdata : sh_b;
      cfg_pending <= (cfg_pending & ~go_vid) | (cfg_wr & (cfg_addr == 3'd4));
      err_ctrl <= (err_ctrl & ~clr) | ctrl_bad;
      err_frame <= (err_frame & ~clr) | frame_bad;
      if (go_vid) begin
        {ac_l, ac_r, ac_t, ac_b} <= {nw_l, nw_r, nw_t, nw_b};
        x <= '0;
        y <= '0;
        video_width <= (lr < {1'b0, in_width}) ? in_width - lr[15:0] : '0;
        video_height <= (tb < {1'b0, in_height}) ? in_height - tb[15:0] : '0;
        video_interlaced <= in_int;
      end
      if (beat) begin
        case (state)
          IDLE: if (sop_hdr) begin
            state <= (din_data[3:0] == 4'hF) ? CTRL : ((din_data[3:0] == 4'h0) ? VID : SKIP);
            bidx <= 4'd1;
          end
          CTRL: begin
            bidx <= (bidx == 4'hF) ? bidx : bidx + 4'd1;
            if (din_endofpacket) begin
              state <= IDLE;
              if (bidx >= REQ) begin
                in_width <= {nib_n[0], nib_n[1], nib_n[2], nib_n[3]};
                in_height <= {nib_n[4], nib_n[5], nib_n[6], nib_n[7]};
                in_int <= nib_n[8];
              end
            end
          end
          VID: begin
            x <= x_last ? '0 : x + 16'd1;
            y <= (x_last && y < in_height) ? y + 16'd1 : y;
            state <= din_endofpacket ? IDLE : VID;
          end
          default: state <= din_endofpacket ? IDLE : state;
        endcase
      end
    end
  end
endmodule
